alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_issue.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU issue logic and whatever instantiates the
//   ALU beside it at the integration level:
//     - ALU control codes (CTRL_TA .. CTRL_EQ, codes 2..11)
//     - the issue FSM state encoding
//     - ctrl_is_legal(): true for the codes the ALU implements
// -----------------------------------------------------------------------------
package alu_pkg;

  // Idle control code: the ALU output is don't-care while this is applied.
  localparam logic [3:0] CTRL_NONE = 4'd0;

  // Implemented ALU operations.
  localparam logic [3:0] CTRL_TA   = 4'd2;   // s = a
  localparam logic [3:0] CTRL_INC  = 4'd3;   // s = a + 1
  localparam logic [3:0] CTRL_ADD  = 4'd4;   // s = a + b
  localparam logic [3:0] CTRL_SUB  = 4'd5;   // s = a - b
  localparam logic [3:0] CTRL_AND  = 4'd6;   // s = a & b
  localparam logic [3:0] CTRL_OR   = 4'd7;   // s = a | b
  localparam logic [3:0] CTRL_XOR  = 4'd8;   // s = a ^ b
  localparam logic [3:0] CTRL_GT   = 4'd9;   // s = (a > b)
  localparam logic [3:0] CTRL_LT   = 4'd10;  // s = (a < b)
  localparam logic [3:0] CTRL_EQ   = 4'd11;  // s = (a == b)

  // Issue FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    EXEC  = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  // A command is legal only if its code lies in the implemented range.
  function automatic logic ctrl_is_legal(input logic [3:0] op);
    return (op >= CTRL_TA) && (op <= CTRL_EQ);
  endfunction

endpackage

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//   Sequences one command at a time onto an external combinational ALU and
//   returns the captured result over a valid/ready response channel.
//
//   Ports
//     clk, rst              clock, synchronous active-high reset
//     cmd_valid/cmd_ready   command handshake
//     cmd_op, cmd_a, cmd_b  ALU control code and operands
//     alu_a, alu_b          operands driven to the ALU
//     alu_ctrl              control code driven to the ALU (0 when not in use)
//     alu_s                 ALU result
//     rsp_valid/rsp_ready   response handshake
//     rsp_data, rsp_err     captured result / illegal-op flag
//     op_count              completed responses (wraps)
//     err_count             illegal-op responses (saturates at 255)
//
//   Legal command flow:   IDLE -> SETUP -> EXEC -> CAPT -> RESP
//   Illegal command flow: IDLE -> RESP  (rsp_data = 0, rsp_err = 1)
//   A RESP handshake coinciding with cmd_valid accepts the next command at
//   once, so back-to-back commands never pass through IDLE.
// -----------------------------------------------------------------------------
module alu_issue
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_ctrl,
  input  logic [7:0] alu_s,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] op_count,
  output logic [7:0] err_count
);

  state_t     state_r;
  logic [3:0] op_r;

  logic       rsp_fire_s;
  logic       cmd_ready_s;
  logic       accept_s;
  logic       cmd_legal_s;

  // Handshake decode. cmd_ready has to follow rsp_ready within the cycle so
  // that a response can be retired and a new command taken on the same edge.
  always_comb begin
    rsp_fire_s  = (state_r == RESP) && rsp_ready;
    cmd_ready_s = (state_r == IDLE) || rsp_fire_s;
    accept_s    = cmd_valid && cmd_ready_s;
    cmd_legal_s = ctrl_is_legal(cmd_op);
  end

  assign cmd_ready = cmd_ready_s;

  // Issue FSM with its registered ALU-side and response-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      op_r      <= CTRL_NONE;
      alu_a     <= 8'd0;
      alu_b     <= 8'd0;
      alu_ctrl  <= CTRL_NONE;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'd0;
      rsp_err   <= 1'b0;
    end else if (accept_s) begin
      // New command, taken either from IDLE or straight out of RESP.
      op_r     <= cmd_op;
      alu_ctrl <= CTRL_NONE;
      if (cmd_legal_s) begin
        // Operands go out one cycle ahead of the ctrl code so the ALU sees a
        // clean 0 -> op transition on alu_ctrl with stable inputs.
        state_r   <= SETUP;
        alu_a     <= cmd_a;
        alu_b     <= cmd_b;
        rsp_valid <= 1'b0;
      end else begin
        // Illegal ops never touch the ALU; alu_a/alu_b keep their old values.
        state_r   <= RESP;
        rsp_valid <= 1'b1;
        rsp_data  <= 8'd0;
        rsp_err   <= 1'b1;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        SETUP: begin
          state_r  <= EXEC;
          alu_ctrl <= op_r;
        end
        EXEC: begin
          state_r  <= CAPT;
          alu_ctrl <= op_r;
        end
        CAPT: begin
          // alu_ctrl has been stable for a full cycle, so alu_s is settled.
          state_r   <= RESP;
          alu_ctrl  <= CTRL_NONE;
          rsp_valid <= 1'b1;
          rsp_data  <= alu_s;
          rsp_err   <= 1'b0;
        end
        RESP: begin
          // rsp_data/rsp_err are left untouched so they stay stable here.
          if (rsp_ready) begin
            state_r   <= IDLE;
            rsp_valid <= 1'b0;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r   <= IDLE;
          alu_ctrl  <= CTRL_NONE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Response statistics, updated only when a response is actually consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count  <= 8'd0;
      err_count <= 8'd0;
    end else if (rsp_fire_s) begin
      op_count <= op_count + 8'd1;
      if (rsp_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end else begin
        err_count <= err_count;
      end
    end else begin
      op_count  <= op_count;
      err_count <= err_count;
    end
  end

endmodule
